// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/data requesters, the arbiter and the
// shared single-port memory.
interface mem_arbiter_if #(
  parameter int B_WIDTH = 32
);
  logic                   if_req;
  logic [B_WIDTH-1:0]     if_addr;
  logic                   if_ready;
  logic                   if_valid;
  logic [B_WIDTH-1:0]     if_rdata;

  logic                   d_req;
  logic                   d_we;
  logic [B_WIDTH/8-1:0]   d_be;
  logic [B_WIDTH-1:0]     d_addr;
  logic [B_WIDTH-1:0]     d_wdata;
  logic                   d_ready;
  logic                   d_valid;
  logic [B_WIDTH-1:0]     d_rdata;

  logic                   m_en;
  logic                   m_we;
  logic [B_WIDTH/8-1:0]   m_be;
  logic [B_WIDTH-1:0]     m_addr;
  logic [B_WIDTH-1:0]     m_wdata;
  logic [B_WIDTH-1:0]     m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
    output if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata,
           m_en, m_we, m_be, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
    input  if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata,
           m_en, m_we, m_be, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and data requesters, one access in flight.
// Define MEM_ARB_RR_EN for round-robin ties; default is data priority with a fetch starvation guard.
module mem_arbiter #(
  parameter int B_WIDTH      = 32,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  // state | meaning
  // IDLE  | accepting; winner's ready and m_en driven combinationally
  // WAIT  | access in flight, counting down memory latency
  // RESP  | one-cycle valid pulse to the owning requester
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t               state_q, state_d;
  logic                 own_data_q, own_data_d;
  logic                 wr_q, wr_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [B_WIDTH-1:0]   rdata_q, rdata_d;
`ifdef MEM_ARB_RR_EN
  logic                 last_data_q, last_data_d;
`else
  logic [3:0]           starve_q, starve_d;
`endif

  logic gnt_if;
  logic gnt_dat;

  // Grants are forced low while reset is asserted.
  always_comb begin
    gnt_if  = 1'b0;
    gnt_dat = 1'b0;
    if (rst && state_q == ST_IDLE) begin
      if (bus.if_req && bus.d_req) begin
`ifdef MEM_ARB_RR_EN
        gnt_if = last_data_q;
`else
        gnt_if = (starve_q == 4'(STARVE_LIMIT));
`endif
        gnt_dat = !gnt_if;
      end else begin
        gnt_if  = bus.if_req;
        gnt_dat = bus.d_req;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    own_data_d = own_data_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
`ifdef MEM_ARB_RR_EN
    last_data_d = last_data_q;
`else
    starve_d    = starve_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_if || gnt_dat) begin
          state_d    = ST_WAIT;
          own_data_d = gnt_dat;
          wr_d       = gnt_dat && bus.d_we;
          cnt_d      = 3'(LATENCY);
`ifdef MEM_ARB_RR_EN
          last_data_d = gnt_dat;
`else
          if (gnt_if) begin
            starve_d = 4'd0;
          end else if (bus.if_req && starve_q < 4'(STARVE_LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
`endif
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = wr_q ? '0 : bus.m_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      own_data_q <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= 3'd0;
      rdata_q    <= '0;
`ifdef MEM_ARB_RR_EN
      last_data_q <= 1'b1;
`else
      starve_q    <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      own_data_q <= own_data_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
`ifdef MEM_ARB_RR_EN
      last_data_q <= last_data_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  assign bus.if_ready = gnt_if;
  assign bus.d_ready  = gnt_dat;

  assign bus.m_en    = gnt_if || gnt_dat;
  assign bus.m_we    = gnt_dat && bus.d_we;
  assign bus.m_be    = gnt_dat ? bus.d_be : '0;
  assign bus.m_addr  = gnt_dat ? bus.d_addr : bus.if_addr;
  assign bus.m_wdata = gnt_dat ? bus.d_wdata : '0;

  assign bus.if_valid = (state_q == ST_RESP) && !own_data_q;
  assign bus.d_valid  = (state_q == ST_RESP) && own_data_q;
  assign bus.if_rdata = bus.if_valid ? rdata_q : '0;
  assign bus.d_rdata  = bus.d_valid ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter with a transaction-level model
// and a behavioural single-port memory.
module tb_mem_arbiter;
  localparam int BW  = 32;
  localparam int LAT = 2;
  localparam int SL  = 4;
  localparam int BEW = BW / 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mem_arbiter_if #(.B_WIDTH(BW)) bus ();

  mem_arbiter #(.B_WIDTH(BW), .LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d actual=timeout required=event", name, cyc);
  endtask

  function automatic logic [BW-1:0] mem_init(input int idx);
    return BW'(idx * 4 + 3);
  endfunction

  // Behavioural memory: writes land at the strobe edge, reads appear LAT cycles later.
  logic [BW-1:0] env_mem [int];
  logic [BW-1:0] rd_pipe [1:LAT];

  always @(posedge clk) begin : env_memory
    int            idx;
    logic [BW-1:0] w;
    idx = int'(bus.m_addr[9:2]);
    w   = env_mem.exists(idx) ? env_mem[idx] : mem_init(idx);
    if (bus.m_en && bus.m_we) begin
      for (int b = 0; b < BEW; b++)
        if (bus.m_be[b]) w[b*8 +: 8] = bus.m_wdata[b*8 +: 8];
      env_mem[idx] = w;
    end
    rd_pipe[1] <= (bus.m_en && !bus.m_we) ? w : 32'hA5A5_5A5A;
    for (int k = 2; k <= LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  assign bus.m_rdata = rd_pipe[LAT];

  // Transaction-level reference: busy window, due response, arbitration history.
  int            free_at = 0;
  int            due_at = -1;
  bit            due_data = 1'b0;
  logic [BW-1:0] due_val = '0;
  int            starve = 0;
  bit            last_data = 1'b1;
  logic [BW-1:0] ref_mem [int];
  byte           gnt_log [$];
  int            gnt_cyc [$];
  int            if_vcnt = 0;

  always @(negedge clk) begin : compare_p
    bit            fw, dw, idle, ev_if, ev_d;
    int            idx;
    logic [BW-1:0] w;
    fw = 1'b0;
    dw = 1'b0;
    if (!rst) begin
      free_at   = 0;
      due_at    = -1;
      starve    = 0;
      last_data = 1'b1;
    end else begin
      idle = (cyc >= free_at);
      if (idle && bus.if_req && bus.d_req) begin
`ifdef MEM_ARB_RR_EN
        fw = last_data;
`else
        fw = (starve == SL);
`endif
        dw = !fw;
      end else if (idle) begin
        fw = bus.if_req;
        dw = bus.d_req;
      end
    end

    chk("if_ready", BW'(bus.if_ready), BW'(fw));
    chk("d_ready", BW'(bus.d_ready), BW'(dw));
    chk("m_en", BW'(bus.m_en), BW'(fw || dw));
    if (fw || dw) begin
      chk("m_addr", bus.m_addr, dw ? bus.d_addr : bus.if_addr);
      chk("m_we", BW'(bus.m_we), BW'(dw && bus.d_we));
      chk("m_be", BW'(bus.m_be), dw ? BW'(bus.d_be) : '0);
      if (dw && bus.d_we) chk("m_wdata", bus.m_wdata, bus.d_wdata);
    end

    ev_if = rst && (cyc == due_at) && !due_data;
    ev_d  = rst && (cyc == due_at) && due_data;
    chk("if_valid", BW'(bus.if_valid), BW'(ev_if));
    chk("d_valid", BW'(bus.d_valid), BW'(ev_d));
    if (ev_if) chk("if_rdata", bus.if_rdata, due_val);
    if (ev_d)  chk("d_rdata", bus.d_rdata, due_val);
    if (!rst) begin
      chk("rst_if_rdata", bus.if_rdata, '0);
      chk("rst_d_rdata", bus.d_rdata, '0);
    end

    if (bus.if_valid) if_vcnt++;
    if (bus.if_req && bus.if_ready) begin gnt_log.push_back("F"); gnt_cyc.push_back(cyc); end
    if (bus.d_req && bus.d_ready)   begin gnt_log.push_back("D"); gnt_cyc.push_back(cyc); end

    if (fw || dw) begin
      free_at   = cyc + LAT + 2;
      due_at    = cyc + LAT + 1;
      due_data  = dw;
      last_data = dw;
      if (fw) begin
        idx     = int'(bus.if_addr[9:2]);
        due_val = ref_mem.exists(idx) ? ref_mem[idx] : mem_init(idx);
        starve  = 0;
      end else begin
        idx = int'(bus.d_addr[9:2]);
        w   = ref_mem.exists(idx) ? ref_mem[idx] : mem_init(idx);
        if (bus.d_we) begin
          for (int b = 0; b < BEW; b++)
            if (bus.d_be[b]) w[b*8 +: 8] = bus.d_wdata[b*8 +: 8];
          ref_mem[idx] = w;
          due_val = '0;
        end else begin
          due_val = w;
        end
        if (bus.if_req && starve < SL) starve++;
      end
    end
  end

  task automatic wait_accept(input bit is_d, output int acc, output logic mwe, output logic [BEW-1:0] mbe);
    acc = -1;
    mwe = 1'b0;
    mbe = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_d ? (bus.d_req && bus.d_ready) : (bus.if_req && bus.if_ready)) begin
        acc = cyc;
        mwe = bus.m_we;
        mbe = bus.m_be;
        return;
      end
    end
    timeout_fail("accept_timeout");
  endtask

  task automatic wait_resp(input bit is_d, output int c, output logic [BW-1:0] v);
    c = -1;
    v = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_d ? bus.d_valid : bus.if_valid) begin
        c = cyc;
        v = is_d ? bus.d_rdata : bus.if_rdata;
        return;
      end
    end
    timeout_fail("resp_timeout");
  endtask

  task automatic issue(input bit is_d, input logic we, input logic [BEW-1:0] be,
                       input logic [BW-1:0] addr, input logic [BW-1:0] wd,
                       output int start, output int acc, output logic mwe, output logic [BEW-1:0] mbe);
    @(posedge clk); #1;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    start = cyc;
    wait_accept(is_d, acc, mwe, mbe);
    @(posedge clk); #1;
    if (is_d) bus.d_req = 1'b0;
    else      bus.if_req = 1'b0;
  endtask

  initial begin : main
    int            t0, acc, s, c, n0, vc0;
    logic          mwe, fa, da;
    logic [BEW-1:0] mbe;
    logic [BW-1:0] v;
    string         exp_seq;

    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_if_ready_lit", BW'(bus.if_ready), 32'd0);
      chk("rst_m_en_lit", BW'(bus.m_en), 32'd0);
      chk("rst_if_valid_lit", BW'(bus.if_valid), 32'd0);
    end

    @(posedge clk); #1;
    rst = 1'b1;
    t0 = cyc;
    wait_accept(1'b0, acc, mwe, mbe);
    chk("release_accept_delay", BW'(acc - t0), 32'd0);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    wait_resp(1'b0, c, v);
    chk("fetch_resp_latency", BW'(c - acc), 32'd3);
    chk("fetch_rdata_lit", v, 32'h0000_0013);

    issue(1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF, s, acc, mwe, mbe);
    chk("write_m_we_lit", BW'(mwe), 32'd1);
    chk("write_m_be_lit", BW'(mbe), 32'h3);
    wait_resp(1'b1, c, v);
    chk("write_resp_latency", BW'(c - acc), 32'd3);
    chk("write_rdata_lit", v, 32'd0);

    issue(1'b1, 1'b0, 4'b0000, 32'h40, 32'd0, s, acc, mwe, mbe);
    wait_resp(1'b1, c, v);
    chk("read_merge_lit", v, 32'h0000_BEEF);

    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    wait_accept(1'b0, t0, mwe, mbe);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = 32'h80;
    wait_accept(1'b1, acc, mwe, mbe);
    chk("held_off_accept", BW'(acc - t0), 32'd4);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    wait_resp(1'b1, c, v);
    chk("held_off_rdata_lit", v, 32'h0000_0083);

`ifdef MEM_ARB_RR_EN
    exp_seq = "FDFDFDFDFD";
`else
    exp_seq = "DDDDFDDDDF";
`endif
    @(posedge clk); #1;
    n0 = gnt_log.size();
    bus.if_req = 1'b1; bus.if_addr = 32'h30;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h50;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt_log.size() - n0 >= 10) break;
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    if (gnt_log.size() - n0 < 10) begin
      timeout_fail("contention_grants");
    end else begin
      for (int k = 0; k < 10; k++) begin
        chk("contention_seq", BW'(gnt_log[n0+k]), BW'(exp_seq[k]));
        if (k > 0) chk("contention_spacing", BW'(gnt_cyc[n0+k] - gnt_cyc[n0+k-1]), 32'd4);
      end
    end
    repeat (6) @(posedge clk);

    vc0 = if_vcnt;
    issue(1'b0, 1'b0, '0, 32'h24, 32'd0, s, acc, mwe, mbe);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("midop_reset_no_valid", BW'(if_vcnt - vc0), 32'd0);
    issue(1'b1, 1'b0, '0, 32'h44, 32'd0, s, acc, mwe, mbe);
    chk("post_reset_idle_accept", BW'(acc - s), 32'd0);
    wait_resp(1'b1, c, v);
    chk("post_reset_rdata_lit", v, 32'h0000_0047);

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      fa = bus.if_req && bus.if_ready;
      da = bus.d_req && bus.d_ready;
      @(posedge clk); #1;
      if (fa || !bus.if_req) begin
        bus.if_req  = ($urandom_range(0, 2) == 0);
        bus.if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end else if ($urandom_range(0, 19) == 0) begin
        bus.if_req = 1'b0;
      end
      if (da || !bus.d_req) begin
        bus.d_req   = ($urandom_range(0, 2) != 0);
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_be    = BEW'($urandom_range(0, 15));
        bus.d_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        bus.d_wdata = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        bus.d_req = 1'b0;
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (8) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
